snes_pad_reader: RTL

//  Polls an SNES-protocol serial gamepad (latch/clock/data) and drives the ten

---
 rtl/snes_pad_if.sv | 34 +++
 rtl/snes_pad_reader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/snes_pad_if.sv
// Pad-side pins and decoded key levels of the SNES pad reader.
// master = the reader (drives the pad strobes and key outputs), slave = consumer/pad side.
interface snes_pad_if;
  logic        poll_now;
  logic        pad_data;
  logic        pad_latch;
  logic        pad_clk;
  logic        KeyA;
  logic        KeyB;
  logic        KeySelect;
  logic        KeyStart;
  logic        KeyRight;
  logic        KeyLeft;
  logic        KeyUp;
  logic        KeyDown;
  logic        KeyR;
  logic        KeyL;
  logic [15:0] keys_raw;
  logic        frame_done;

  modport master (
    input  poll_now, pad_data,
    output pad_latch, pad_clk,
    output KeyA, KeyB, KeySelect, KeyStart, KeyRight, KeyLeft, KeyUp, KeyDown, KeyR, KeyL,
    output keys_raw, frame_done
  );

  modport slave (
    output poll_now, pad_data,
    input  pad_latch, pad_clk,
    input  KeyA, KeyB, KeySelect, KeyStart, KeyRight, KeyLeft, KeyUp, KeyDown, KeyR, KeyL,
    input  keys_raw, frame_done
  );
endinterface

// File: rtl/snes_pad_reader.sv
// Polls an SNES serial gamepad and presents ten active-high key levels plus the raw frame.
// state  | meaning
// IDLE   | waiting for interval wrap or poll_now
// LATCH  | latch strobe high for 2*HALF cycles
// GAP    | latch low, clock high for HALF cycles; bit 0 sampled on last cycle
// CLK_LO | serial clock low for HALF cycles
// CLK_HI | serial clock high for HALF cycles; bit n sampled on last cycle
// DONE   | one cycle; key outputs, keys_raw and frame_done update together
module snes_pad_reader #(
  parameter int HALF          = 100,
  parameter int POLL_INTERVAL = 279620,
  parameter bit SOCD_CLEAN    = 1'b1
) (
  input  logic        mclk,
  input  logic        resetn,
  snes_pad_if.master  pad
);

  localparam int CW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam int PW = $clog2(2 * HALF);
  localparam logic [CW-1:0] INT_LAST = CW'(POLL_INTERVAL - 1);
  localparam logic [PW-1:0] PH_2H    = PW'(2 * HALF - 1);
  localparam logic [PW-1:0] PH_H     = PW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, LATCH, GAP, CLK_LO, CLK_HI, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   int_cnt_q, int_cnt_d;
  logic [PW-1:0]   ph_cnt_q, ph_cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     sr_q, sr_d;
  logic [1:0]      sync_q;
  logic            latch_q, pclk_q, done_q;
  logic [9:0]      keys_q, keys_d;
  logic [15:0]     raw_q;
  logic            int_wrap, ph_end, pad_bit;
  logic            ud_clr, lr_clr;

  assign int_wrap = (int_cnt_q == INT_LAST);
  assign ph_end   = (ph_cnt_q == '0);
  assign pad_bit  = ~sync_q[1];

  always_comb begin
    state_d   = state_q;
    int_cnt_d = int_wrap ? '0 : int_cnt_q + 1'b1;
    ph_cnt_d  = ph_end ? ph_cnt_q : ph_cnt_q - 1'b1;
    bit_d     = bit_q;
    sr_d      = sr_q;
    unique case (state_q)
      IDLE: begin
        if (pad.poll_now || int_wrap) begin
          state_d  = LATCH;
          ph_cnt_d = PH_2H;
          if (pad.poll_now) int_cnt_d = '0;
        end
      end
      LATCH: begin
        if (ph_end) begin
          state_d  = GAP;
          ph_cnt_d = PH_H;
        end
      end
      GAP: begin
        if (ph_end) begin
          sr_d[0]  = pad_bit;
          bit_d    = 4'd1;
          state_d  = CLK_LO;
          ph_cnt_d = PH_H;
        end
      end
      CLK_LO: begin
        if (ph_end) begin
          state_d  = CLK_HI;
          ph_cnt_d = PH_H;
        end
      end
      CLK_HI: begin
        if (ph_end) begin
          sr_d[bit_q] = pad_bit;
          ph_cnt_d    = PH_H;
          if (bit_q == 4'd15) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = CLK_LO;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Opposing directions cancel out when SOCD cleaning is enabled; keys_raw stays unfiltered.
  always_comb begin
    ud_clr = SOCD_CLEAN && sr_q[4] && sr_q[5];
    lr_clr = SOCD_CLEAN && sr_q[6] && sr_q[7];
    keys_d = {sr_q[8], sr_q[0], sr_q[2], sr_q[3],
              sr_q[7] & ~lr_clr, sr_q[6] & ~lr_clr,
              sr_q[4] & ~ud_clr, sr_q[5] & ~ud_clr,
              sr_q[11], sr_q[10]};
  end

  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      int_cnt_q <= '0;
      ph_cnt_q  <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      sync_q    <= 2'b11;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
      done_q    <= 1'b0;
      keys_q    <= '0;
      raw_q     <= '0;
    end else begin
      state_q   <= state_d;
      int_cnt_q <= int_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      sync_q    <= {sync_q[0], pad.pad_data};
      latch_q   <= (state_d == LATCH);
      pclk_q    <= (state_d != CLK_LO);
      done_q    <= (state_q == DONE);
      if (state_q == DONE) begin
        keys_q <= keys_d;
        raw_q  <= sr_q;
      end
    end
  end

  assign pad.pad_latch  = latch_q;
  assign pad.pad_clk    = pclk_q;
  assign pad.frame_done = done_q;
  assign pad.keys_raw   = raw_q;
  assign {pad.KeyA, pad.KeyB, pad.KeySelect, pad.KeyStart, pad.KeyRight,
          pad.KeyLeft, pad.KeyUp, pad.KeyDown, pad.KeyR, pad.KeyL} = keys_q;

endmodule
